reg_scoreboard: RTL and testbench

Tracks pending register-file writes for the five-stage pipeline and stalls decode on read-after-write hazards. It sits beside the register file between decode and writeback. It keeps one saturating pending-write counter per general register: decode increments the counter when it issues an instruction that targets the register, and writeback decrements it when the result is written. Decode must hold an instruction while any source register it reads has an uncommitted write.

---
 rtl/reg_scoreboard.sv | 90 +++++++++
 tb/tb_reg_scoreboard.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register-file write scoreboard: one saturating pending-write counter per register,
// stalling decode on read-after-write hazards and on destination-counter saturation.
module reg_scoreboard #(
  parameter int unsigned REG_NUMBER = 8,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned CNT_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic                    issue_src1_used,
  input  logic [ADDR_W-1:0]       issue_src1,
  input  logic                    issue_src2_used,
  input  logic [ADDR_W-1:0]       issue_src2,
  input  logic                    issue_dst_used,
  input  logic [ADDR_W-1:0]       issue_dst,
  input  logic                    wb_valid,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic                    flush,
  output logic                    issue_stall,
  output logic                    issue_accept,
  output logic [REG_NUMBER-1:0]   busy_vec,
  output logic [ADDR_W+CNT_W-1:0] pend_total,
  output logic                    underflow_err
);

  localparam int unsigned PT_W = ADDR_W + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]      cnt_q [REG_NUMBER];
  logic [CNT_W-1:0]      cnt_d [REG_NUMBER];
  logic [CNT_W-1:0]      eff   [REG_NUMBER];
  logic [REG_NUMBER-1:0] wb_hit;
  logic [REG_NUMBER-1:0] inc;
  logic [REG_NUMBER-1:0] dec;
  logic [REG_NUMBER-1:0] busy_d, busy_q;
  logic [PT_W-1:0]       pend_d, pend_q;
  logic                  uf_d, uf_q;
  logic                  src_hazard;
  logic                  dst_full;

  // eff is the count as seen by a reader this cycle: a retiring writeback is already visible.
  always_comb begin
    wb_hit = '0;
    for (int unsigned i = 0; i < REG_NUMBER; i++) begin
      wb_hit[i] = wb_valid && (wb_addr == ADDR_W'(i));
      eff[i]    = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(wb_hit[i]) : '0;
    end
  end

  assign src_hazard   = (issue_src1_used && (eff[issue_src1] != '0)) ||
                        (issue_src2_used && (eff[issue_src2] != '0));
  assign dst_full     = issue_dst_used && (eff[issue_dst] == CNT_MAX);
  assign issue_stall  = issue_valid && (src_hazard || dst_full);
  assign issue_accept = issue_valid && !issue_stall;

  always_comb begin
    inc    = '0;
    dec    = '0;
    busy_d = '0;
    pend_d = '0;
    for (int unsigned i = 0; i < REG_NUMBER; i++) begin
      inc[i]    = issue_accept && issue_dst_used && (issue_dst == ADDR_W'(i));
      dec[i]    = wb_hit[i] && (cnt_q[i] != '0);
      cnt_d[i]  = flush ? '0 : cnt_q[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
      busy_d[i] = (cnt_d[i] != '0);
      pend_d    = pend_d + PT_W'(cnt_d[i]);
    end
    uf_d = uf_q || (wb_valid && (cnt_q[wb_addr] == '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < REG_NUMBER; i++) cnt_q[i] <= '0;
      busy_q <= '0;
      pend_q <= '0;
      uf_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < REG_NUMBER; i++) cnt_q[i] <= cnt_d[i];
      busy_q <= busy_d;
      pend_q <= pend_d;
      uf_q   <= uf_d;
    end
  end

  assign busy_vec      = busy_q;
  assign pend_total    = pend_q;
  assign underflow_err = uf_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed table-driven bench for reg_scoreboard: each row is one cycle of inputs with
// the expected combinational stall/accept and the registered outputs after the edge.
module tb_reg_scoreboard;

  logic       clk;
  logic       rst;
  logic       issue_valid, issue_src1_used, issue_src2_used, issue_dst_used;
  logic [2:0] issue_src1, issue_src2, issue_dst;
  logic       wb_valid;
  logic [2:0] wb_addr;
  logic       flush;
  logic       issue_stall, issue_accept;
  logic [7:0] busy_vec;
  logic [4:0] pend_total;
  logic       underflow_err;

  int n_checks = 0;
  int n_fail   = 0;

  reg_scoreboard #(.REG_NUMBER(8), .ADDR_W(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid),
    .issue_src1_used(issue_src1_used), .issue_src1(issue_src1),
    .issue_src2_used(issue_src2_used), .issue_src2(issue_src2),
    .issue_dst_used(issue_dst_used), .issue_dst(issue_dst),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .issue_stall(issue_stall), .issue_accept(issue_accept),
    .busy_vec(busy_vec), .pend_total(pend_total), .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       s1u; logic [2:0] s1;
    logic       s2u; logic [2:0] s2;
    logic       du;  logic [2:0] d;
    logic       wb;  logic [2:0] wa;
    logic       fl;
    logic       st;  logic ac;
    logic [7:0] busy; logic [4:0] pend; logic uf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic v, logic s1u, logic [2:0] s1, logic s2u, logic [2:0] s2,
                              logic du, logic [2:0] d, logic wb, logic [2:0] wa, logic fl,
                              logic st, logic ac, logic [7:0] busy, logic [4:0] pend, logic uf);
    vec_t t;
    t.v = v; t.s1u = s1u; t.s1 = s1; t.s2u = s2u; t.s2 = s2; t.du = du; t.d = d;
    t.wb = wb; t.wa = wa; t.fl = fl; t.st = st; t.ac = ac; t.busy = busy; t.pend = pend; t.uf = uf;
    tbl.push_back(t);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s1u, input logic [2:0] s1,
                       input logic s2u, input logic [2:0] s2, input logic du, input logic [2:0] d,
                       input logic wb, input logic [2:0] wa, input logic fl);
    issue_valid = v; issue_src1_used = s1u; issue_src1 = s1;
    issue_src2_used = s2u; issue_src2 = s2; issue_dst_used = du; issue_dst = d;
    wb_valid = wb; wb_addr = wa; flush = fl;
  endtask

  initial begin
    //  v s1u s1 s2u s2 du d  wb wa fl   st ac busy   pend uf
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 0); // idle
    add(1, 0, 0, 0, 0, 1, 5, 0, 0, 0,   0, 1, 8'h20, 1, 0); // issue dst5
    add(1, 1, 5, 0, 0, 0, 0, 0, 0, 0,   1, 0, 8'h20, 1, 0); // RAW on r5
    add(1, 1, 5, 0, 0, 0, 0, 1, 5, 0,   0, 1, 8'h00, 0, 0); // same-cycle wb clears hazard
    add(1, 0, 0, 0, 0, 1, 2, 0, 0, 0,   0, 1, 8'h04, 1, 0);
    add(1, 0, 0, 0, 0, 1, 2, 0, 0, 0,   0, 1, 8'h04, 2, 0);
    add(1, 0, 0, 0, 0, 1, 2, 0, 0, 0,   0, 1, 8'h04, 3, 0);
    add(1, 0, 0, 0, 0, 1, 2, 0, 0, 0,   1, 0, 8'h04, 3, 0); // saturated dst
    add(1, 0, 0, 0, 0, 1, 2, 1, 2, 0,   0, 1, 8'h04, 3, 0); // wb frees a slot, count stays 3
    add(1, 0, 0, 0, 0, 1, 4, 0, 0, 0,   0, 1, 8'h14, 4, 0);
    add(1, 0, 0, 0, 0, 1, 4, 1, 4, 0,   0, 1, 8'h14, 4, 0); // inc+dec same reg
    add(0, 0, 0, 0, 0, 0, 0, 1, 6, 0,   0, 0, 8'h14, 4, 1); // underflow on r6
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 8'h14, 4, 1); // sticky
    add(1, 0, 0, 0, 0, 1, 0, 1, 2, 0,   0, 1, 8'h15, 4, 1);
    add(1, 0, 0, 0, 0, 1, 1, 1, 2, 0,   0, 1, 8'h17, 4, 1);
    add(1, 0, 0, 0, 0, 1, 1, 1, 2, 0,   0, 1, 8'h13, 4, 1);
    add(1, 0, 0, 0, 0, 1, 3, 0, 0, 0,   0, 1, 8'h1B, 5, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 4, 0,   0, 0, 8'h0B, 4, 1); // cnt = {1,2,0,1,0,...}
    add(1, 0, 0, 0, 0, 1, 0, 0, 0, 1,   0, 1, 8'h00, 0, 1); // flush beats accepted issue
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 8'h00, 0, 1);
    add(1, 0, 0, 0, 0, 1, 6, 0, 0, 0,   0, 1, 8'h40, 1, 1);
    add(1, 0, 0, 1, 6, 0, 0, 0, 0, 0,   1, 0, 8'h40, 1, 1); // RAW via src2
    add(1, 0, 0, 0, 6, 0, 0, 0, 0, 0,   0, 1, 8'h40, 1, 1); // src2 unused
    add(0, 1, 6, 0, 0, 0, 0, 0, 0, 0,   0, 0, 8'h40, 1, 1); // no stall without valid
    add(1, 1, 7, 0, 0, 1, 7, 0, 0, 0,   0, 1, 8'hC0, 2, 1); // self-dep: pre-issue count
    add(1, 1, 7, 0, 0, 1, 7, 0, 0, 0,   1, 0, 8'hC0, 2, 1);

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_busy", -1, busy_vec, 8'h00);
    chk("reset_pend", -1, pend_total, 0);
    chk("reset_uf", -1, underflow_err, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].s1u, tbl[i].s1, tbl[i].s2u, tbl[i].s2,
            tbl[i].du, tbl[i].d, tbl[i].wb, tbl[i].wa, tbl[i].fl);
      #1;
      chk("stall", i, issue_stall, tbl[i].st);
      chk("accept", i, issue_accept, tbl[i].ac);
      @(posedge clk); #1;
      chk("busy_vec", i, busy_vec, tbl[i].busy);
      chk("pend_total", i, pend_total, tbl[i].pend);
      chk("underflow", i, underflow_err, tbl[i].uf);
    end

    // Asynchronous reset mid-run with cnt[3] = 2 and underflow set.
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_pend", 100, pend_total, 4);
    drive(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_stall", 100, issue_stall, 1);
    rst = 1'b0;
    #1;
    chk("async_busy", 100, busy_vec, 8'h00);
    chk("async_pend", 100, pend_total, 0);
    chk("async_uf", 100, underflow_err, 0);
    chk("async_stall", 100, issue_stall, 0);
    chk("async_accept", 100, issue_accept, 1);
    #1 rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk("post_rst_busy", 101, busy_vec, 8'h00);
    chk("post_rst_pend", 101, pend_total, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
